seg_scan_ctrl: RTL and testbench

SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

---
 rtl/seg_pkg.sv | 36 +++
 rtl/seg_hex_decode.sv | 11 +
 rtl/seg_scan_ctrl.sv | 163 ++++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared definitions for the seven-segment scan controller: glyph table,
// blank pattern and handshake state encoding.
package seg_pkg;

  typedef enum logic {
    HS_IDLE = 1'b0,
    HS_PEND = 1'b1
  } hs_state_t;

  // Cathodes are {g,f,e,d,c,b,a}, active-low; all ones is a dark digit.
  localparam logic [6:0] SEG_OFF = 7'h7F;

  localparam logic [6:0] GLYPH_TBL [16] = '{
    7'b1000000,  // 0
    7'b1111001,  // 1
    7'b0100100,  // 2
    7'b0110000,  // 3
    7'b0011001,  // 4
    7'b0010010,  // 5
    7'b0000010,  // 6
    7'b1111000,  // 7
    7'b0000000,  // 8
    7'b0010000,  // 9
    7'b0001000,  // A
    7'b0000011,  // b
    7'b1000110,  // C
    7'b0100001,  // d
    7'b0000110,  // E
    7'b0001110   // F
  };

  function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
    return GLYPH_TBL[nib];
  endfunction

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational hex nibble to active-low seven-segment glyph.
module seg_hex_decode
  import seg_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  assign seg = hex_glyph(hex);

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed seven-segment scanner with frame-synchronous double-buffered
// value updates and optional leading-zero blanking.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int DIV      = 100000,
  parameter int BLANK_LZ = 1
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic [DIGITS-1:0]     dig_en,
  output logic                  ready,
  output logic [6:0]            seg,
  output logic [DIGITS-1:0]     an,
  output logic                  dp,
  output logic                  frame
);

  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IDX_W = $clog2(DIGITS);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(DIGITS - 1);

  logic [CNT_W-1:0]    cnt_p0;
  logic [IDX_W-1:0]    idx_p0;
  logic                tick;
  logic                wrap;

  hs_state_t           state;
  hs_state_t           state_nxt;
  logic                capture;
  logic                commit;

  logic [4*DIGITS-1:0] shadow_val;
  logic [DIGITS-1:0]   shadow_dp;
  logic [4*DIGITS-1:0] active_val;
  logic [DIGITS-1:0]   active_dp;

  logic [DIGITS-1:0]   blank;
  logic                zero_above;
  logic [3:0]          nib;
  logic [6:0]          glyph;
  logic                lit;
  logic [DIGITS-1:0]   an_nxt;
  logic [6:0]          seg_nxt;
  logic                dp_nxt;

  logic [DIGITS-1:0]   an_p1;
  logic [6:0]          seg_p1;
  logic                dp_p1;
  logic                frame_p1;

  // p0: slot timing -- prescaler and digit index
  assign tick = (cnt_p0 == CNT_MAX);
  assign wrap = tick && (idx_p0 == IDX_MAX);

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      cnt_p0 <= '0;
      idx_p0 <= '0;
    end else begin
      if (tick) begin
        cnt_p0 <= '0;
        idx_p0 <= (idx_p0 == IDX_MAX) ? '0 : idx_p0 + 1'b1;
      end else begin
        cnt_p0 <= cnt_p0 + 1'b1;
      end
    end
  end

  // Load handshake: one pending update at a time, committed only on a frame wrap.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) state <= HS_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      HS_IDLE: if (load)  state_nxt = HS_PEND;
      HS_PEND: if (wrap)  state_nxt = HS_IDLE;
      default:            state_nxt = HS_IDLE;
    endcase
  end

  always_comb begin
    ready   = (state == HS_IDLE);
    capture = (state == HS_IDLE) && load;
    commit  = (state == HS_PEND) && wrap;
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      shadow_val <= '0;
      shadow_dp  <= '0;
      active_val <= '0;
      active_dp  <= '0;
    end else begin
      if (capture) begin
        shadow_val <= value;
        shadow_dp  <= dp_in;
      end
      if (commit) begin
        active_val <= shadow_val;
        active_dp  <= shadow_dp;
      end
    end
  end

  // A digit is blanked when it and every more-significant nibble are zero.
  always_comb begin
    blank      = '0;
    zero_above = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      zero_above = zero_above && (active_val[4*i +: 4] == 4'h0);
      blank[i]   = (BLANK_LZ != 0) && (i != 0) && zero_above;
    end
  end

  assign nib = active_val[4*idx_p0 +: 4];

  seg_hex_decode u_dec (
    .hex (nib),
    .seg (glyph)
  );

  always_comb begin
    lit     = dig_en[idx_p0] && !blank[idx_p0];
    an_nxt  = '1;
    seg_nxt = SEG_OFF;
    dp_nxt  = 1'b1;
    if (lit) begin
      an_nxt[idx_p0] = 1'b0;
      seg_nxt        = glyph;
      dp_nxt         = ~active_dp[idx_p0];
    end
  end

  // p1: registered pad drive
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      an_p1    <= '1;
      seg_p1   <= SEG_OFF;
      dp_p1    <= 1'b1;
      frame_p1 <= 1'b0;
    end else begin
      an_p1    <= an_nxt;
      seg_p1   <= seg_nxt;
      dp_p1    <= dp_nxt;
      frame_p1 <= wrap;
    end
  end

  assign an    = an_p1;
  assign seg   = seg_p1;
  assign dp    = dp_p1;
  assign frame = frame_p1;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with DIGITS=4, DIV=4 (16-cycle frame).
module tb_seg_scan_ctrl;

  logic        clk = 1'b0;
  logic        clr;
  logic        load;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic [3:0]  dig_en;
  logic        ready;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        dp;
  logic        frame;

  int checks = 0;
  int errors = 0;

  seg_scan_ctrl #(.DIGITS(4), .DIV(4), .BLANK_LZ(1)) dut (
    .clk    (clk),
    .clr    (clr),
    .load   (load),
    .value  (value),
    .dp_in  (dp_in),
    .dig_en (dig_en),
    .ready  (ready),
    .seg    (seg),
    .an     (an),
    .dp     (dp),
    .frame  (frame)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  en;
    logic [15:0] val;
    logic [3:0]  dpi;
    logic [15:0] an_e;   // {slot3, slot2, slot1, slot0}
    logic [27:0] sg_e;   // {slot3, slot2, slot1, slot0}
    logic [3:0]  dp_e;   // bit d = expected dp in slot d
  } vec_t;

  vec_t vecs [6];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_frame(input string nm, input logic [15:0] an_e,
                             input logic [27:0] sg_e, input logic [3:0] dp_e);
    for (int d = 0; d < 4; d++) begin
      for (int c = 0; c < 4; c++) begin
        step();
        chk($sformatf("%s an d%0d c%0d", nm, d, c), 32'(an), 32'(an_e[4*d +: 4]));
        chk($sformatf("%s seg d%0d c%0d", nm, d, c), 32'(seg), 32'(sg_e[7*d +: 7]));
        chk($sformatf("%s dp d%0d c%0d", nm, d, c), 32'(dp), 32'(dp_e[d]));
        chk($sformatf("%s frame d%0d c%0d", nm, d, c), 32'(frame), 32'((d == 3) && (c == 3)));
      end
    end
  endtask

  task automatic wait_frame_ready(input string nm);
    bit seen = 1'b0;
    for (int i = 0; i < 64; i++) begin
      step();
      if (frame && ready) begin
        seen = 1'b1;
        break;
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s: no frame with ready within 64 cycles, got none expected frame=1 ready=1", nm);
    end
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] d);
    value = v;
    dp_in = d;
    load  = 1'b1;
    step();
    load  = 1'b0;
  endtask

  initial begin
    vecs[0] = '{en: 4'hF, val: 16'h8888, dpi: 4'h0, an_e: 16'h7BDE,
                sg_e: {7'h00, 7'h00, 7'h00, 7'h00}, dp_e: 4'hF};
    vecs[1] = '{en: 4'hF, val: 16'h1234, dpi: 4'h0, an_e: 16'h7BDE,
                sg_e: {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001}, dp_e: 4'hF};
    vecs[2] = '{en: 4'hF, val: 16'h0050, dpi: 4'h0, an_e: 16'hFFDE,
                sg_e: {7'h7F, 7'h7F, 7'b0010010, 7'b1000000}, dp_e: 4'hF};
    vecs[3] = '{en: 4'b0101, val: 16'h8888, dpi: 4'b0001, an_e: 16'hFBFE,
                sg_e: {7'h7F, 7'h00, 7'h7F, 7'h00}, dp_e: 4'b1110};
    vecs[4] = '{en: 4'hF, val: 16'h0000, dpi: 4'hF, an_e: 16'hFFFE,
                sg_e: {7'h7F, 7'h7F, 7'h7F, 7'b1000000}, dp_e: 4'b1110};
    vecs[5] = '{en: 4'hF, val: 16'hF00A, dpi: 4'b0100, an_e: 16'h7BDE,
                sg_e: {7'b0001110, 7'b1000000, 7'b1000000, 7'b0001000}, dp_e: 4'b1011};

    clr    = 1'b1;
    load   = 1'b0;
    value  = 16'h0;
    dp_in  = 4'h0;
    dig_en = 4'hF;
    step();
    step();
    chk("rst an", 32'(an), 32'hF);
    chk("rst seg", 32'(seg), 32'h7F);
    chk("rst dp", 32'(dp), 32'h1);
    chk("rst frame", 32'(frame), 32'h0);
    chk("rst ready", 32'(ready), 32'h1);
    clr = 1'b0;

    // Zeroed active register: only digit 0 lit, showing "0".
    check_frame("post_rst", 16'hFFFE, {7'h7F, 7'h7F, 7'h7F, 7'b1000000}, 4'hF);

    foreach (vecs[i]) begin
      dig_en = vecs[i].en;
      do_load(vecs[i].val, vecs[i].dpi);
      chk($sformatf("v%0d ready_low", i), 32'(ready), 32'h0);
      wait_frame_ready($sformatf("v%0d wait", i));
      check_frame($sformatf("v%0d", i), vecs[i].an_e, vecs[i].sg_e, vecs[i].dp_e);
    end

    // Second load while pending is dropped.
    dig_en = 4'hF;
    do_load(16'h1234, 4'h0);
    chk("hs ready_low", 32'(ready), 32'h0);
    do_load(16'h5678, 4'hF);
    chk("hs ignored ready", 32'(ready), 32'h0);
    wait_frame_ready("hs wait");
    check_frame("hs first", vecs[1].an_e, vecs[1].sg_e, vecs[1].dp_e);

    // Load on the wrap-tick cycle waits a whole extra frame.
    for (int i = 0; i < 15; i++) step();
    do_load(16'h8888, 4'h0);
    chk("wrap_load frame", 32'(frame), 32'h1);
    chk("wrap_load ready", 32'(ready), 32'h0);
    check_frame("wrap_old", vecs[1].an_e, vecs[1].sg_e, vecs[1].dp_e);
    chk("wrap_commit ready", 32'(ready), 32'h1);
    check_frame("wrap_new", vecs[0].an_e, vecs[0].sg_e, vecs[0].dp_e);

    // Asynchronous clear in the middle of the digit-2 slot.
    do_load(16'h1234, 4'h0);
    for (int i = 0; i < 9; i++) step();
    chk("mid slot2 an", 32'(an), 32'hB);
    chk("mid ready_low", 32'(ready), 32'h0);
    #2;
    clr = 1'b1;
    #1;
    chk("async an", 32'(an), 32'hF);
    chk("async seg", 32'(seg), 32'h7F);
    chk("async dp", 32'(dp), 32'h1);
    chk("async ready", 32'(ready), 32'h1);
    chk("async frame", 32'(frame), 32'h0);
    step();
    clr = 1'b0;
    check_frame("after_clr", 16'hFFFE, {7'h7F, 7'h7F, 7'h7F, 7'b1000000}, 4'hF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
